prf_wb_arbiter: RTL and testbench

- Shares the two physical-register-file write ports among six functional-unit completion requesters: sim0, sim1, mul0, mul1, mem0 and mem1, as requester indices 0..5.
- Sits between the ALU/MUL/MEM result stages and the PRF write inputs.
- Grants up to two requests per cycle under rotating round-robin priority.
- Registers the winners onto the PRF write ports, so results reach the PRF write ports one cycle after grant.
- Checks write indices and flags out-of-range writes.

---
 rtl/prf_wb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_prf_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_wb_arbiter.sv
// Purpose : shares two PRF write ports among six FU completion requesters, round-robin.
// Latency : grant is combinational; the granted results drive the write ports one cycle later.
// Backpres: wb_stall or reset suppresses every grant. Ungranted requesters hold their request.
//
// Ports
//   clock, reset        posedge clock; synchronous active-high reset
//   req_valid[r]        requester r (sim0, sim1, mul0, mul1, mem0, mem1) has a result
//   req_idx / req_value requester r fields at [IDX_W*r +: IDX_W] / [DATA_W*r +: DATA_W]
//   wb_stall            blocks all grants this cycle
//   grant[r]            combinational accept; valid & grant at posedge = transfer
//   wr_*0 / wr_*1       registered PRF write ports (port 0 = first winner)
//   idx_err             sticky flag for a granted out-of-range index
//   busy_cycles         saturating count of congested or stalled-with-work cycles
module prf_wb_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int IDX_W     = 7,
  parameter int DATA_W    = 64,
  parameter int NUM_PREGS = 96
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  input  logic                      wb_stall,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_enable0,
  output logic [IDX_W-1:0]          wr_idx0,
  output logic [DATA_W-1:0]         wr_value0,
  output logic                      wr_enable1,
  output logic [IDX_W-1:0]          wr_idx1,
  output logic [DATA_W-1:0]         wr_value1,
  output logic                      idx_err,
  output logic [15:0]               busy_cycles
);

  // Pointer logic is sized for six requesters (values 0..5 fit in 3 bits).
  localparam int PTR_W = 3;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] value;
  } wb_req_t;

  localparam logic [PTR_W:0] NUM_REQ_W  = (PTR_W+1)'(NUM_REQ);
  localparam logic [IDX_W:0] PREG_LIMIT = (IDX_W+1)'(NUM_PREGS);

  // Modular add for operands already in 0..NUM_REQ-1; one conditional
  // subtract is enough because the sum never reaches 2*NUM_REQ.
  function automatic ptr_t ptr_add(input ptr_t base, input ptr_t off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    return sum[PTR_W-1:0];
  endfunction

  ptr_t           rr_ptr;
  ptr_t           cand;
  ptr_t           a_sel;
  ptr_t           b_sel;
  ptr_t           last_sel;
  logic           a_found;
  logic           b_found;
  wb_req_t        a_req;
  wb_req_t        b_req;
  logic           a_legal;
  logic           b_legal;
  logic [PTR_W:0] valid_cnt;
  logic           busy_hit;

  // Scan requesters starting at rr_ptr; the first two valid ones win.
  // Reset is folded in here so nothing can be consumed during reset.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    cand    = '0;
    if (!reset && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ptr_add(rr_ptr, ptr_t'(k));
        if (req_valid[cand]) begin
          if (!a_found) begin
            a_found = 1'b1;
            a_sel   = cand;
          end else if (!b_found) begin
            b_found = 1'b1;
            b_sel   = cand;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (a_found) begin
      grant[a_sel] = 1'b1;
    end
    if (b_found) begin
      grant[b_sel] = 1'b1;
    end
  end

  // Winner payload selection.
  always_comb begin
    a_req.idx   = req_idx[int'(a_sel)*IDX_W +: IDX_W];
    a_req.value = req_value[int'(a_sel)*DATA_W +: DATA_W];
    b_req.idx   = req_idx[int'(b_sel)*IDX_W +: IDX_W];
    b_req.value = req_value[int'(b_sel)*DATA_W +: DATA_W];
  end

  assign a_legal  = ({1'b0, a_req.idx} < PREG_LIMIT);
  assign b_legal  = ({1'b0, b_req.idx} < PREG_LIMIT);
  assign last_sel = b_found ? b_sel : a_sel;

  // Congestion: more requests than write ports, or work blocked by stall.
  always_comb begin
    valid_cnt = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      valid_cnt = valid_cnt + {{PTR_W{1'b0}}, req_valid[r]};
    end
    busy_hit = (valid_cnt > 4'd2) || (wb_stall && (|req_valid));
  end

  // Round-robin pointer: resume just after the last requester served.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (a_found) begin
      rr_ptr <= ptr_add(last_sel, ptr_t'(1));
    end
  end

  // Write port 0. Index/value hold when nothing is granted; an illegal
  // index is consumed but never enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_enable0 <= 1'b0;
      wr_idx0    <= '0;
      wr_value0  <= '0;
    end else begin
      wr_enable0 <= a_found && a_legal;
      if (a_found) begin
        wr_idx0   <= a_req.idx;
        wr_value0 <= a_req.value;
      end
    end
  end

  // Write port 1. Equal indices on both ports are written as-is; the PRF
  // applies port 1 after port 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_enable1 <= 1'b0;
      wr_idx1    <= '0;
      wr_value1  <= '0;
    end else begin
      wr_enable1 <= b_found && b_legal;
      if (b_found) begin
        wr_idx1   <= b_req.idx;
        wr_value1 <= b_req.value;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_err <= 1'b0;
    end else if ((a_found && !a_legal) || (b_found && !b_legal)) begin
      idx_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cycles <= '0;
    end else if (busy_hit && (busy_cycles != 16'hFFFF)) begin
      busy_cycles <= busy_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Purpose : directed plus random checking of prf_wb_arbiter against a behavioural model.
// Latency : each cycle() call drives one cycle, checks grant mid-cycle and ports after the edge.
// Backpres: requesters hold requests until the model says they were granted.
module tb_prf_wb_arbiter;

  logic          clock;
  logic          reset;
  logic [5:0]    req_valid;
  logic [41:0]   req_idx;
  logic [383:0]  req_value;
  logic          wb_stall;
  logic [5:0]    grant;
  logic          wr_enable0;
  logic [6:0]    wr_idx0;
  logic [63:0]   wr_value0;
  logic          wr_enable1;
  logic [6:0]    wr_idx1;
  logic [63:0]   wr_value1;
  logic          idx_err;
  logic [15:0]   busy_cycles;

  prf_wb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_idx     (req_idx),
    .req_value   (req_value),
    .wb_stall    (wb_stall),
    .grant       (grant),
    .wr_enable0  (wr_enable0),
    .wr_idx0     (wr_idx0),
    .wr_value0   (wr_value0),
    .wr_enable1  (wr_enable1),
    .wr_idx1     (wr_idx1),
    .wr_value1   (wr_value1),
    .idx_err     (idx_err),
    .busy_cycles (busy_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;

  // Requester-side state: what each FU is currently offering.
  bit          pend [6];
  int          ridx [6];
  logic [63:0] rval [6];

  // Reference model state.
  int          m_ptr;
  bit          m_en0, m_en1, m_err;
  int          m_idx0, m_idx1, m_busy;
  logic [63:0] m_val0, m_val1;

  logic [5:0]  obs_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rotating scan from ptr; first two pending requesters win.
  function automatic void model_arb(input bit blocked, output int a, output int b);
    a = -1;
    b = -1;
    if (blocked) return;
    for (int k = 0; k < 6; k++) begin
      int r;
      r = (m_ptr + k) % 6;
      if (pend[r]) begin
        if (a < 0) a = r;
        else if (b < 0) b = r;
      end
    end
  endfunction

  task automatic set_req(input int r, input int idx, input logic [63:0] val);
    pend[r] = 1'b1;
    ridx[r] = idx;
    rval[r] = val;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < 6; r++) pend[r] = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_en0 = 0; m_en1 = 0; m_err = 0;
    m_idx0 = 0; m_idx1 = 0; m_busy = 0;
    m_val0 = '0; m_val1 = '0;
  endtask

  task automatic cycle(input bit stall_i, input bit rst_i);
    int ea, eb, nv;
    logic [5:0] eg;
    for (int r = 0; r < 6; r++) begin
      req_valid[r]          = pend[r];
      req_idx[r*7 +: 7]     = 7'(ridx[r]);
      req_value[r*64 +: 64] = rval[r];
    end
    wb_stall = stall_i;
    reset    = rst_i;
    model_arb(stall_i || rst_i, ea, eb);
    eg = '0;
    if (ea >= 0) eg[ea] = 1'b1;
    if (eb >= 0) eg[eb] = 1'b1;
    @(negedge clock);
    obs_grant = grant;
    chk("grant", {58'd0, grant}, {58'd0, eg});
    @(posedge clock);
    #1;
    if (rst_i) begin
      model_reset();
    end else begin
      nv = 0;
      for (int r = 0; r < 6; r++) nv += int'(pend[r]);
      if ((nv > 2 || (stall_i && nv > 0)) && m_busy < 65535) m_busy++;
      if (ea >= 0) begin
        m_idx0 = ridx[ea]; m_val0 = rval[ea]; m_en0 = (ridx[ea] < 96);
        if (ridx[ea] >= 96) m_err = 1;
      end else begin
        m_en0 = 0;
      end
      if (eb >= 0) begin
        m_idx1 = ridx[eb]; m_val1 = rval[eb]; m_en1 = (ridx[eb] < 96);
        if (ridx[eb] >= 96) m_err = 1;
      end else begin
        m_en1 = 0;
      end
      if (eb >= 0) m_ptr = (eb + 1) % 6;
      else if (ea >= 0) m_ptr = (ea + 1) % 6;
      if (ea >= 0) pend[ea] = 1'b0;
      if (eb >= 0) pend[eb] = 1'b0;
    end
    chk("wr_enable0",  {63'd0, wr_enable0}, {63'd0, m_en0});
    chk("wr_idx0",     {57'd0, wr_idx0},    64'(m_idx0));
    chk("wr_value0",   wr_value0,           m_val0);
    chk("wr_enable1",  {63'd0, wr_enable1}, {63'd0, m_en1});
    chk("wr_idx1",     {57'd0, wr_idx1},    64'(m_idx1));
    chk("wr_value1",   wr_value1,           m_val1);
    chk("idx_err",     {63'd0, idx_err},    {63'd0, m_err});
    chk("busy_cycles", {48'd0, busy_cycles}, 64'(m_busy));
    chk("rr_ptr",      {61'd0, dut.rr_ptr}, 64'(m_ptr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_g [3];
    n_cmp = 0;
    n_err = 0;
    for (int r = 0; r < 6; r++) begin
      pend[r] = 1'b0; ridx[r] = 0; rval[r] = '0;
    end
    model_reset();
    reset     = 1'b1;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_idx   = '0;
    req_value = '0;
    repeat (2) @(posedge clock);
    #1;

    // Requests present during reset are not consumed.
    for (int r = 0; r < 6; r++) set_req(r, r + 1, 64'(r));
    cycle(0, 1);
    chk("rst_grant_zero", {58'd0, obs_grant}, 64'd0);
    clear_reqs();

    // Single request to port 0.
    set_req(0, 10, 64'hAA);
    cycle(0, 0);
    chk("t1_grant", {58'd0, obs_grant}, 64'b000001);
    chk("t1_en0",   {63'd0, wr_enable0}, 64'd1);
    chk("t1_idx0",  {57'd0, wr_idx0},    64'd10);
    chk("t1_val0",  wr_value0,           64'hAA);
    chk("t1_en1",   {63'd0, wr_enable1}, 64'd0);

    // All six continuously valid from pointer 0.
    cycle(0, 1);
    exp_g[0] = 6'b000011; exp_g[1] = 6'b001100; exp_g[2] = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 6; r++) set_req(r, 20 + r + 6 * i, {$urandom, $urandom});
      cycle(0, 0);
      chk("t2_grant", {58'd0, obs_grant}, {58'd0, exp_g[i]});
    end
    chk("t2_busy", {48'd0, busy_cycles}, 64'd3);
    chk("t2_ptr_wrap", {61'd0, dut.rr_ptr}, 64'd0);
    clear_reqs();

    // Wrap-around pair from pointer 4.
    set_req(3, 40, 64'h33);
    cycle(0, 0);
    set_req(4, 30, 64'h44);
    set_req(0, 31, 64'h00);
    cycle(0, 0);
    chk("t3_grant", {58'd0, obs_grant}, 64'b010001);
    chk("t3_idx0",  {57'd0, wr_idx0},    64'd30);
    chk("t3_idx1",  {57'd0, wr_idx1},    64'd31);
    chk("t3_ptr",   {61'd0, dut.rr_ptr}, 64'd1);

    // Out-of-range index is consumed, never written, and sticks.
    set_req(2, 100, 64'hBAD);
    cycle(0, 0);
    chk("t4_grant", {58'd0, obs_grant}, 64'b000100);
    chk("t4_en0",   {63'd0, wr_enable0}, 64'd0);
    chk("t4_err",   {63'd0, idx_err},    64'd1);
    repeat (10) cycle(0, 0);
    chk("t4_err_sticky", {63'd0, idx_err}, 64'd1);

    // Same index on both ports: both written.
    set_req(0, 5, 64'h50);
    set_req(1, 5, 64'h51);
    cycle(0, 0);
    chk("same_en0", {63'd0, wr_enable0}, 64'd1);
    chk("same_en1", {63'd0, wr_enable1}, 64'd1);
    chk("same_idx1", {57'd0, wr_idx1},   64'd5);

    // Stall for two cycles, then release.
    set_req(0, 11, 64'h60);
    set_req(1, 12, 64'h61);
    cycle(1, 0);
    chk("t5_grant_s0", {58'd0, obs_grant}, 64'd0);
    cycle(1, 0);
    chk("t5_grant_s1", {58'd0, obs_grant}, 64'd0);
    chk("t5_en0", {63'd0, wr_enable0}, 64'd0);
    cycle(0, 0);
    chk("t5_grant_go", {58'd0, obs_grant}, 64'b000011);

    // Grant, then reset on the next cycle with one request still held.
    set_req(0, 13, 64'h70);
    set_req(1, 14, 64'h71);
    set_req(2, 15, 64'h72);
    cycle(0, 0);
    chk("t6_grant", {58'd0, obs_grant}, 64'b000101);
    cycle(0, 1);
    chk("t6_en0_rst", {63'd0, wr_enable0}, 64'd0);
    chk("t6_ptr_rst", {61'd0, dut.rr_ptr}, 64'd0);
    cycle(0, 0);
    chk("t6_regrant", {58'd0, obs_grant}, 64'b000010);

    // Random traffic with occasional stalls, resets and illegal indices.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 6; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1)
          set_req(r, int'($urandom_range(0, 103)), {$urandom, $urandom});
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
